// File: rtl/gpr_serial_bank_pkg.sv
// Shared types and helpers for the bit-serial register bank.
// Holds FSM/register-op enums and the reset-image slicing function.
package gpr_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } gpr_state_e;

  typedef enum logic [1:0] {
    HOLD,
    ROTATE,
    SHIFT_IN,
    LOAD
  } gpr_op_e;

  localparam int GPR_MAX_W   = 64;
  localparam int GPR_MAX_IMG = 1024;

  // Caller truncates the result to its own register width.
  function automatic logic [GPR_MAX_W-1:0] init_slice(
    input logic [GPR_MAX_IMG-1:0] img,
    input int unsigned            width,
    input int unsigned            n
  );
    logic [GPR_MAX_IMG-1:0] sh;
    sh = img >> (n * width);
    return sh[GPR_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/gpr_serial_bank_shift_reg.sv
// One WIDTH-bit register of the bank: hold, rotate right, shift a serial
// bit into the MSB, or parallel load.
module gpr_shift_reg
  import gpr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  gpr_op_e          i_op,
  input  logic             i_ser,
  input  logic [WIDTH-1:0] i_pdata,
  input  logic [WIDTH-1:0] i_rst_val,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= i_rst_val;
    end else begin
      case (i_op)
        HOLD:     r_q <= r_q;
        ROTATE:   r_q <= {r_q[0], r_q[WIDTH-1:1]};
        SHIFT_IN: r_q <= {i_ser, r_q[WIDTH-1:1]};
        LOAD:     r_q <= i_pdata;
        default:  r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gpr_serial_bank.sv
// Bit-serial register bank: streams two sources LSB-first while shifting a
// result into a destination over a fixed WIDTH-cycle start/done transaction.
module gpr_serial_bank
  import gpr_pkg::*;
#(
  parameter int                     WIDTH = 8,
  parameter int                     NREGS = 4,
  parameter logic [WIDTH*NREGS-1:0] INIT  = {8'h50, 8'h30, 8'h00, 8'h00},
  localparam int                    AW    = $clog2(NREGS),
  localparam int                    BW    = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [AW-1:0]    i_ra_addr,
  input  logic [AW-1:0]    i_rb_addr,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic             i_wr_en,
  input  logic             i_data_in,
  input  logic             i_load,
  input  logic [AW-1:0]    i_load_addr,
  input  logic [WIDTH-1:0] i_load_data,
  output logic             o_ra_bit,
  output logic             o_rb_bit,
  output logic             o_busy,
  output logic             o_done,
  output logic [BW-1:0]    o_bit_idx,
  output logic [WIDTH-1:0] o_data_display
);

  gpr_state_e       r_state;
  logic [AW-1:0]    r_ra;
  logic [AW-1:0]    r_rb;
  logic [AW-1:0]    r_wr;
  logic             r_wr_en;
  logic [BW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_q [NREGS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_wr    <= '0;
      r_wr_en <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= SHIFT;
            r_ra    <= i_ra_addr;
            r_rb    <= i_rb_addr;
            r_wr    <= i_wr_addr;
            r_wr_en <= i_wr_en;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (r_cnt == BW'(WIDTH - 1)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A register shifts at most once per cycle; the write takes priority over
  // rotation so read-modify-write of the same register works in place.
  for (genvar n = 0; n < NREGS; n++) begin : g_reg
    localparam logic [WIDTH-1:0] RST_VAL =
      WIDTH'(init_slice(GPR_MAX_IMG'(INIT), WIDTH, n));
    gpr_op_e w_op;

    always_comb begin
      w_op = HOLD;
      if (r_state == IDLE) begin
        if (i_load && (i_load_addr == AW'(n))) w_op = LOAD;
      end else if (r_wr_en && (r_wr == AW'(n))) begin
        w_op = SHIFT_IN;
      end else if ((r_ra == AW'(n)) || (r_rb == AW'(n))) begin
        w_op = ROTATE;
      end
    end

    gpr_shift_reg #(
      .WIDTH(WIDTH)
    ) u_reg (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_op     (w_op),
      .i_ser    (i_data_in),
      .i_pdata  (i_load_data),
      .i_rst_val(RST_VAL),
      .o_q      (w_q[n])
    );
  end

  assign o_ra_bit       = (r_state == SHIFT) ? w_q[r_ra][0] : 1'b0;
  assign o_rb_bit       = (r_state == SHIFT) ? w_q[r_rb][0] : 1'b0;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_bit_idx      = r_cnt;
  assign o_data_display = w_q[0];

endmodule

// File: tb/tb_gpr_serial_bank.sv
// Directed bench for gpr_serial_bank with hand-computed expected streams.
module tb_gpr_serial_bank;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [1:0] i_ra_addr = '0;
  logic [1:0] i_rb_addr = '0;
  logic [1:0] i_wr_addr = '0;
  logic       i_wr_en = 1'b0;
  logic       i_data_in = 1'b0;
  logic       i_load = 1'b0;
  logic [1:0] i_load_addr = '0;
  logic [7:0] i_load_data = '0;
  logic       o_ra_bit;
  logic       o_rb_bit;
  logic       o_busy;
  logic       o_done;
  logic [2:0] o_bit_idx;
  logic [7:0] o_data_display;

  int n_chk = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  gpr_serial_bank dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_ra_addr     (i_ra_addr),
    .i_rb_addr     (i_rb_addr),
    .i_wr_addr     (i_wr_addr),
    .i_wr_en       (i_wr_en),
    .i_data_in     (i_data_in),
    .i_load        (i_load),
    .i_load_addr   (i_load_addr),
    .i_load_data   (i_load_data),
    .o_ra_bit      (o_ra_bit),
    .o_rb_bit      (o_rb_bit),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_bit_idx     (o_bit_idx),
    .o_data_display(o_data_display)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one full transaction; inputs change and outputs are sampled on negedges.
  // inv feeds back ~o_ra_bit; noise pokes i_start/i_load mid-transaction.
  task automatic txn(input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] wr,
                     input logic we, input logic [7:0] din, input bit inv, input bit noise,
                     output logic [7:0] aw, output logic [7:0] bw);
    @(negedge i_clk);
    i_start = 1'b1; i_ra_addr = ra; i_rb_addr = rb; i_wr_addr = wr; i_wr_en = we;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      aw[j] = o_ra_bit;
      bw[j] = o_rb_bit;
      chk("busy_shift", {31'd0, o_busy}, 32'd1);
      chk("bit_idx", {29'd0, o_bit_idx}, j);
      i_data_in   = inv ? ~o_ra_bit : din[j];
      i_start     = noise && (j == 2);
      i_load      = noise && (j == 2);
      i_load_addr = 2'd1;
      i_load_data = 8'hFF;
      @(negedge i_clk);
    end
    i_data_in = 1'b0;
    chk("done_pulse", {31'd0, o_done}, 32'd1);
    chk("busy_at_done", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic read_reg(input logic [1:0] r, output logic [7:0] v);
    logic [7:0] b;
    txn(r, r, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, v, b);
    chk("read_ab_same", {24'd0, b}, {24'd0, v});
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] v;

    // Reset state
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_idx", {29'd0, o_bit_idx}, 32'd0);
    chk("rst_ra_bit", {31'd0, o_ra_bit}, 32'd0);
    chk("rst_rb_bit", {31'd0, o_rb_bit}, 32'd0);
    chk("rst_display", {24'd0, o_data_display}, 32'h00);

    // Plain read of reg2/reg3: streams 0x30 and 0x50, both unchanged afterwards
    txn(2'd2, 2'd3, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, a, b);
    chk("read_a_stream", {24'd0, a}, 32'h30);
    chk("read_b_stream", {24'd0, b}, 32'h50);
    read_reg(2'd2, v); chk("reg2_kept", {24'd0, v}, 32'h30);
    read_reg(2'd3, v); chk("reg3_kept", {24'd0, v}, 32'h50);

    // Serial write of 0xA5 into reg0
    txn(2'd2, 2'd3, 2'd0, 1'b1, 8'hA5, 1'b0, 1'b0, a, b);
    chk("write_display", {24'd0, o_data_display}, 32'hA5);
    chk("write_src_a", {24'd0, a}, 32'h30);

    // In-place invert of reg3
    txn(2'd3, 2'd2, 2'd3, 1'b1, 8'h00, 1'b1, 1'b0, a, b);
    chk("inplace_a_stream", {24'd0, a}, 32'h50);
    chk("inplace_b_stream", {24'd0, b}, 32'h30);
    read_reg(2'd3, v); chk("reg3_inverted", {24'd0, v}, 32'hAF);

    // ra == rb: single shift per cycle
    txn(2'd2, 2'd2, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, a, b);
    chk("same_a", {24'd0, a}, 32'h30);
    chk("same_b", {24'd0, b}, 32'h30);
    read_reg(2'd2, v); chk("reg2_after_same", {24'd0, v}, 32'h30);

    // Parallel load, then read with start/load poked during SHIFT
    @(negedge i_clk);
    i_load = 1'b1; i_load_addr = 2'd1; i_load_data = 8'h7E;
    @(negedge i_clk);
    i_load = 1'b0;
    txn(2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, a, b);
    chk("load_stream", {24'd0, a}, 32'h7E);
    chk("load_b_reg0", {24'd0, b}, 32'hA5);
    @(negedge i_clk);
    chk("no_queued_start", {31'd0, o_busy}, 32'd0);
    read_reg(2'd1, v); chk("reg1_load_ignored", {24'd0, v}, 32'h7E);

    // Reset at bit 4 of a write to reg0
    @(negedge i_clk);
    i_start = 1'b1; i_ra_addr = 2'd2; i_rb_addr = 2'd3; i_wr_addr = 2'd0; i_wr_en = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_data_in = 1'b1;
    repeat (4) @(negedge i_clk);
    chk("pre_abort_idx", {29'd0, o_bit_idx}, 32'd4);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0; i_data_in = 1'b0;
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_done", {31'd0, o_done}, 32'd0);
    chk("abort_idx", {29'd0, o_bit_idx}, 32'd0);
    chk("abort_reg0", {24'd0, o_data_display}, 32'h00);
    @(negedge i_clk);
    chk("abort_no_late_done", {31'd0, o_done}, 32'd0);
    read_reg(2'd2, v); chk("abort_reg2", {24'd0, v}, 32'h30);
    read_reg(2'd1, v); chk("abort_reg1_init", {24'd0, v}, 32'h00);
    read_reg(2'd3, v); chk("abort_reg3_init", {24'd0, v}, 32'h50);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
